// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver at a fixed CLKS_PER_BIT, no oversampling.
// Optional: define UART_RX_START_VALIDATE_EN to re-check the start bit at mid-bit.
module uart_rx_fsm #(
  parameter int unsigned CLKS_PER_BIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_rst,
  input  logic       tx_data_out,
  output logic       rx_busy,
  output logic       rx_done,
  output logic       error,
  output logic [7:0] rx_data_out
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          stop_q, stop_n;
  logic          stop_ok;
  logic          load;
  logic          mid, last;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    stop_n  = stop_q;
    stop_ok = stop_q;
    load    = 1'b0;
    mid     = (cnt == MID);
    last    = (cnt == LAST);
    rx_busy = 1'b0;
    rx_done = 1'b0;
    error   = 1'b0;

    case (state)
      IDLE, DONE: begin
        rx_done = (state == DONE);
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        // The detecting edge is already clock 0 of the start bit.
        if (!tx_data_out) begin
          if (CLKS_PER_BIT == 1) begin
            state_n = DATA;
          end else begin
            state_n = START;
            cnt_n   = CW'(1);
          end
        end
      end
      START: begin
        rx_busy = 1'b1;
        cnt_n   = last ? '0 : cnt + CW'(1);
        if (last) state_n = DATA;
`ifdef UART_RX_START_VALIDATE_EN
        if (mid && tx_data_out) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
`endif
      end
      DATA: begin
        rx_busy = 1'b1;
        cnt_n   = last ? '0 : cnt + CW'(1);
        if (mid) shreg_n[idx] = tx_data_out;
        if (last) begin
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        rx_busy = 1'b1;
        cnt_n   = last ? '0 : cnt + CW'(1);
        // Sample and period end coincide when CLKS_PER_BIT is 1 or 2.
        if (mid) begin
          stop_n  = tx_data_out;
          stop_ok = tx_data_out;
        end
        if (last) begin
          state_n = stop_ok ? DONE : ERROR;
          load    = stop_ok;
        end
      end
      ERROR: begin
        error = 1'b1;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      stop_q      <= 1'b0;
      rx_data_out <= '0;
    end else if (soft_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      stop_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      stop_q <= stop_n;
      if (load) rx_data_out <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm; received bytes are checked against a scoreboard queue.
module tb_uart_rx_fsm;

  localparam int unsigned CPB = 3;

  logic       clk;
  logic       rst;
  logic       soft_rst;
  logic       tx_data_out;
  logic       rx_busy;
  logic       rx_done;
  logic       error;
  logic [7:0] rx_data_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_rx_fsm #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_rst   (soft_rst),
    .tx_data_out(tx_data_out),
    .rx_busy    (rx_busy),
    .rx_done    (rx_done),
    .error      (error),
    .rx_data_out(rx_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the oldest outstanding byte.
  always @(negedge clk) begin
    if (rx_done !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got done=%b data=%h required no pulse", rx_done, rx_data_out);
      end else begin
        logic [7:0] exp;
        exp = exp_q.pop_front();
        if (rx_data_out !== exp) begin
          errors++;
          $display("FAIL rx_byte got %h required %h", rx_data_out, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    tx_data_out = 1'b0;
    repeat (CPB) tick();
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start got %b required 1", rx_busy);
    end
    for (int i = 0; i < 8; i++) begin
      tx_data_out = b[i];
      repeat (CPB) tick();
      checks++;
      if (rx_busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_data%0d got %b required 1 (byte %h)", i, rx_busy, b);
      end
    end
    tx_data_out = stop;
    repeat (CPB) tick();
    checks++;
    if ({rx_busy, rx_done, error} !== {1'b0, stop, ~stop}) begin
      errors++;
      $display("FAIL frame_end got busy/done/err=%b%b%b required %b%b%b (byte %h)",
               rx_busy, rx_done, error, 1'b0, stop, ~stop, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; soft_rst = 1'b0; tx_data_out = 1'b0;
    repeat (36) begin
      tick();
      checks++;
      if ({rx_busy, rx_done, error} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs got %b%b%b required 000", rx_busy, rx_done, error);
      end
    end
    checks++;
    if (rx_data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h required 00", rx_data_out);
    end
  endtask

  task automatic test_soft_reset();
    rst = 1'b0; soft_rst = 1'b1; tx_data_out = 1'b0;
    repeat (36) begin
      tick();
      checks++;
      if ({rx_busy, rx_done, error} !== 3'b000) begin
        errors++;
        $display("FAIL soft_reset_outputs got %b%b%b required 000", rx_busy, rx_done, error);
      end
    end
    tx_data_out = 1'b1;
    tick();
    soft_rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b required 0", rx_busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1);
    tx_data_out = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_framing_error();
    send_frame(8'h33, 1'b0);
    tx_data_out = 1'b1;
    tick();
    tx_data_out = 1'b0;
    repeat (30) begin
      tick();
      checks++;
      if ({error, rx_done, rx_busy, rx_data_out} !== {3'b100, 8'hFF}) begin
        errors++;
        $display("FAIL error_sticky got err=%b done=%b busy=%b data=%h required 1 0 0 ff",
                 error, rx_done, rx_busy, rx_data_out);
      end
    end
    soft_rst = 1'b1;
    tick();
    checks++;
    if ({error, rx_busy, rx_data_out} !== {2'b00, 8'hFF}) begin
      errors++;
      $display("FAIL error_clear got err=%b busy=%b data=%h required 0 0 ff", error, rx_busy, rx_data_out);
    end
    tx_data_out = 1'b1;
    tick();
    soft_rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_abort();
    tx_data_out = 1'b0;
    repeat (CPB) tick();
    tx_data_out = 1'b1;
    repeat (2 * CPB) tick();
    soft_rst = 1'b1;
    tick();
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got %b required 0", rx_busy);
    end
    soft_rst = 1'b0;
    repeat (12 * CPB) tick();
    send_frame(8'hA5, 1'b1);
    tx_data_out = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_glitch();
    tx_data_out = 1'b0;
    tick();
    tx_data_out = 1'b1;
`ifdef UART_RX_START_VALIDATE_EN
    tick();
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject got busy=%b required 0", rx_busy);
    end
`else
    exp_q.push_back(8'hFF);
`endif
    repeat (10 * CPB) tick();
    checks++;
    if (exp_q.size() != 0 || error !== 1'b0) begin
      errors++;
      $display("FAIL glitch_outcome got pending=%0d err=%b required 0 0", exp_q.size(), error);
    end
  endtask

  task automatic test_reset_clears_data();
    rst = 1'b1;
    tick();
    checks++;
    if (rx_data_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_data got %h required 00", rx_data_out);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_soft_reset();
    test_back_to_back();
    test_framing_error();
    test_abort();
    test_glitch();
    test_reset_clears_data();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_done got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
